// File: rtl/wisc_mem_pkg.sv
// Shared types and constants for the WISC memory stage.
package wisc_mem_pkg;

  localparam int unsigned DATA_W = 16;
  localparam logic [3:0]  REG_SP = 4'hF;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/ack bus between the memory stage (master) and data memory (slave).
interface mem_access_unit_if
  import wisc_mem_pkg::*;
#(
  parameter int unsigned DATA_W = wisc_mem_pkg::DATA_W
) ();

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );

endinterface

// File: rtl/mem_access_unit.sv
// Pipeline memory stage: variable-latency data-memory access with stall, timeout and
// registered MEM/WB results (including popped return PC for ret).
module mem_access_unit
  import wisc_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned DATA_W         = wisc_mem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              RegWrite_in,
  input  logic              MemWrite_in,
  input  logic              MemRead_in,
  input  logic              mem_to_reg_in,
  input  logic              call_in,
  input  logic              ret_future_in,
  input  logic [3:0]        reg_rd_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] sw_data_in,
  input  logic              HALT_in,
  mem_access_unit_if.master dmem,
  output logic              mem_stall,
  output logic              wb_valid,
  output logic              RegWrite_out,
  output logic [3:0]        reg_rd_out,
  output logic [DATA_W-1:0] wb_data,
  output logic              ret_pc_valid,
  output logic [DATA_W-1:0] ret_pc,
  output logic              HALT_out,
  output logic              mem_error
);

  mem_state_t        state, state_nxt;
  logic [7:0]        wait_cnt;
  logic              req_q, we_q;
  logic [DATA_W-1:0] addr_q, wdata_q;
  logic              cap_regwrite, cap_m2r, cap_call, cap_ret;
  logic [3:0]        cap_rd;

  logic is_mem, timeout_hit;
  logic accept_alu, start_mem, complete, time_out;

  // HALT always takes the single-cycle path, even if memory bits are set.
  assign is_mem      = (MemRead_in | MemWrite_in) & ~HALT_in;
  assign timeout_hit = (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    mem_stall  = 1'b0;
    accept_alu = 1'b0;
    start_mem  = 1'b0;
    complete   = 1'b0;
    time_out   = 1'b0;
    case (state)
      IDLE: begin
        if (ex_valid && !HALT_out) begin
          if (is_mem) begin
            mem_stall = 1'b1;
            start_mem = 1'b1;
            state_nxt = WAIT;
          end else begin
            accept_alu = 1'b1;
          end
        end
      end
      WAIT: begin
        if (dmem.dmem_ack) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end else if (timeout_hit) begin
          time_out  = 1'b1;
          state_nxt = IDLE;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The captured address doubles as the captured ALU result for write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt     <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cap_regwrite <= 1'b0;
      cap_m2r      <= 1'b0;
      cap_call     <= 1'b0;
      cap_ret      <= 1'b0;
      cap_rd       <= '0;
      wb_valid     <= 1'b0;
      RegWrite_out <= 1'b0;
      reg_rd_out   <= '0;
      wb_data      <= '0;
      ret_pc_valid <= 1'b0;
      ret_pc       <= '0;
      HALT_out     <= 1'b0;
      mem_error    <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      ret_pc_valid <= 1'b0;

      if (accept_alu) begin
        wb_valid     <= 1'b1;
        RegWrite_out <= RegWrite_in;
        reg_rd_out   <= reg_rd_in;
        wb_data      <= alu_result_in;
        if (HALT_in) HALT_out <= 1'b1;
      end

      if (start_mem) begin
        req_q        <= 1'b1;
        we_q         <= MemWrite_in;
        addr_q       <= alu_result_in;
        wdata_q      <= sw_data_in;
        cap_regwrite <= RegWrite_in;
        cap_m2r      <= mem_to_reg_in;
        cap_call     <= call_in;
        cap_ret      <= ret_future_in;
        cap_rd       <= reg_rd_in;
        wait_cnt     <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if (complete) begin
        req_q        <= 1'b0;
        wb_valid     <= 1'b1;
        RegWrite_out <= cap_regwrite;
        reg_rd_out   <= cap_rd;
        wb_data      <= (cap_m2r && !cap_ret && !cap_call) ? dmem.dmem_rdata : addr_q;
        if (cap_ret) begin
          ret_pc       <= dmem.dmem_rdata;
          ret_pc_valid <= 1'b1;
        end
      end

      if (time_out) begin
        req_q        <= 1'b0;
        wb_valid     <= 1'b1;
        RegWrite_out <= 1'b0;
        mem_error    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a transaction-level model.
module tb_mem_access_unit;

  localparam int unsigned TO = 4;

  typedef struct {
    logic        regwrite;
    logic        wr;
    logic        rd;
    logic        m2r;
    logic        call;
    logic        ret;
    logic [3:0]  dst;
    logic [15:0] alu;
    logic [15:0] sw;
    logic        halt;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        RegWrite_in = 1'b0, MemWrite_in = 1'b0, MemRead_in = 1'b0;
  logic        mem_to_reg_in = 1'b0, call_in = 1'b0, ret_future_in = 1'b0, HALT_in = 1'b0;
  logic [3:0]  reg_rd_in = '0;
  logic [15:0] alu_result_in = '0, sw_data_in = '0;
  logic        mem_stall, wb_valid, RegWrite_out, ret_pc_valid, HALT_out, mem_error;
  logic [3:0]  reg_rd_out;
  logic [15:0] wb_data, ret_pc;

  mem_access_unit_if #(.DATA_W(16)) bus ();

  mem_access_unit #(.TIMEOUT_CYCLES(TO), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid),
    .RegWrite_in(RegWrite_in), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
    .mem_to_reg_in(mem_to_reg_in), .call_in(call_in), .ret_future_in(ret_future_in),
    .reg_rd_in(reg_rd_in), .alu_result_in(alu_result_in), .sw_data_in(sw_data_in),
    .HALT_in(HALT_in), .dmem(bus), .mem_stall(mem_stall), .wb_valid(wb_valid),
    .RegWrite_out(RegWrite_out), .reg_rd_out(reg_rd_out), .wb_data(wb_data),
    .ret_pc_valid(ret_pc_valid), .ret_pc(ret_pc), .HALT_out(HALT_out), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model of the architecturally visible WB state (values hold between instructions).
  logic        e_regwrite = 1'b0;
  logic [3:0]  e_rd = '0;
  logic [15:0] e_wb = '0, e_retpc = '0;
  logic        e_err = 1'b0, e_halt = 1'b0;

  task automatic model_reset();
    e_regwrite = 1'b0; e_rd = '0; e_wb = '0; e_retpc = '0; e_err = 1'b0; e_halt = 1'b0;
  endtask

  task automatic drive(input instr_t in, input logic v);
    ex_valid = v; RegWrite_in = in.regwrite; MemWrite_in = in.wr; MemRead_in = in.rd;
    mem_to_reg_in = in.m2r; call_in = in.call; ret_future_in = in.ret; reg_rd_in = in.dst;
    alu_result_in = in.alu; sw_data_in = in.sw; HALT_in = in.halt;
  endtask

  function automatic instr_t mk(input int kind, input logic [3:0] dst, input logic [15:0] alu,
                                input logic [15:0] sw);
    instr_t i;
    i = '{regwrite: 1'b0, wr: 1'b0, rd: 1'b0, m2r: 1'b0, call: 1'b0, ret: 1'b0,
          dst: dst, alu: alu, sw: sw, halt: 1'b0};
    case (kind)
      0: i.regwrite = 1'b1;                                           // ALU
      1: begin i.rd = 1'b1; i.m2r = 1'b1; i.regwrite = 1'b1; end      // LW
      2: i.wr = 1'b1;                                                 // SW
      3: begin i.wr = 1'b1; i.call = 1'b1; i.regwrite = 1'b1; i.dst = 4'hF; end
      4: begin i.rd = 1'b1; i.ret = 1'b1; i.regwrite = 1'b1; i.dst = 4'hF; end
      5: i.halt = 1'b1;
      default: ;
    endcase
    return i;
  endfunction

  // One instruction from issue to the cycle after its WB pulse; ack_at > TO means no ack.
  task automatic do_instr(input string nm, input instr_t in, input int ack_at,
                          input logic [15:0] rdata);
    logic is_mem, acked, done, e_rpv;
    is_mem = in.rd | in.wr;
    acked = 1'b0; done = 1'b0; e_rpv = 1'b0;
    @(negedge clk);
    drive(in, 1'b1);
    #1;
    n_checks++;
    if (mem_stall !== is_mem) $display("FAIL %s issue_stall: got %b expected %b", nm, mem_stall, is_mem);
    else n_pass++;
    @(negedge clk);
    ex_valid = 1'b0;
    if (is_mem) begin
      n_checks++;
      if (bus.dmem_req !== 1'b1 || bus.dmem_we !== in.wr || bus.dmem_addr !== in.alu ||
          bus.dmem_wdata !== in.sw || wb_valid !== 1'b0)
        $display("FAIL %s bus: got req=%b we=%b addr=%h wdata=%h wbv=%b expected 1 %b %h %h 0",
                 nm, bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata, wb_valid,
                 in.wr, in.alu, in.sw);
      else n_pass++;
      for (int k = 1; k <= int'(TO) && !done; k++) begin
        if (k == ack_at) begin
          bus.dmem_ack = 1'b1; bus.dmem_rdata = rdata;
          #1;
          n_checks++;
          if (mem_stall !== 1'b0) $display("FAIL %s ack_stall: got %b expected 0", nm, mem_stall);
          else n_pass++;
          @(negedge clk);
          bus.dmem_ack = 1'b0;
          acked = 1'b1; done = 1'b1;
        end else begin
          #1;
          n_checks++;
          if (mem_stall !== (k != int'(TO)) || bus.dmem_req !== 1'b1 || bus.dmem_addr !== in.alu)
            $display("FAIL %s wait%0d: got stall=%b req=%b addr=%h expected %b 1 %h",
                     nm, k, mem_stall, bus.dmem_req, bus.dmem_addr, k != int'(TO), in.alu);
          else n_pass++;
          @(negedge clk);
          if (k == int'(TO)) done = 1'b1;
        end
      end
      if (acked) begin
        e_regwrite = in.regwrite; e_rd = in.dst;
        e_wb = (in.m2r && !in.ret && !in.call) ? rdata : in.alu;
        if (in.ret) begin e_retpc = rdata; e_rpv = 1'b1; end
      end else begin
        e_regwrite = 1'b0; e_err = 1'b1;
      end
    end else begin
      e_regwrite = in.regwrite; e_rd = in.dst; e_wb = in.alu;
      if (in.halt) e_halt = 1'b1;
    end
    n_checks++;
    if (wb_valid !== 1'b1 || RegWrite_out !== e_regwrite || reg_rd_out !== e_rd ||
        wb_data !== e_wb || ret_pc_valid !== e_rpv || ret_pc !== e_retpc ||
        mem_error !== e_err || HALT_out !== e_halt || bus.dmem_req !== 1'b0)
      $display("FAIL %s wb: got v=%b rw=%b rd=%h d=%h rpv=%b rpc=%h err=%b halt=%b req=%b expected 1 %b %h %h %b %h %b %b 0",
               nm, wb_valid, RegWrite_out, reg_rd_out, wb_data, ret_pc_valid, ret_pc, mem_error,
               HALT_out, bus.dmem_req, e_regwrite, e_rd, e_wb, e_rpv, e_retpc, e_err, e_halt);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (wb_valid !== 1'b0 || ret_pc_valid !== 1'b0)
      $display("FAIL %s pulse: got wbv=%b rpv=%b expected 0 0", nm, wb_valid, ret_pc_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.dmem_req !== 1'b0 || wb_valid !== 1'b0 || wb_data !== '0 || mem_error !== 1'b0 ||
        HALT_out !== 1'b0 || ret_pc !== '0 || mem_stall !== 1'b0)
      $display("FAIL reset: got req=%b wbv=%b d=%h err=%b halt=%b rpc=%h stall=%b expected all 0",
               bus.dmem_req, wb_valid, wb_data, mem_error, HALT_out, ret_pc, mem_stall);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    do_instr("add",  mk(0, 4'd3, 16'h1234, 16'h0000), 0, 16'h0);
    do_instr("lw",   mk(1, 4'd5, 16'h0040, 16'h0000), 3, 16'hBEEF);
    do_instr("call", mk(3, 4'd0, 16'hFFFE, 16'h0102), 1, 16'h5555);
    do_instr("ret",  mk(4, 4'd0, 16'hFFFF, 16'h0000), 2, 16'h0103);
  endtask

  task automatic test_timeout();
    do_instr("timeout", mk(1, 4'd7, 16'h0080, 16'h0000), TO + 1, 16'h0);
    do_instr("add_after_to", mk(0, 4'd2, 16'h00AA, 16'h0000), 0, 16'h0);
  endtask

  task automatic test_ack_outside_wait();
    @(negedge clk);
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 16'hDEAD;
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    n_checks++;
    if (wb_valid !== 1'b0 || bus.dmem_req !== 1'b0 || wb_data !== e_wb)
      $display("FAIL stray_ack: got wbv=%b req=%b d=%h expected 0 0 %h", wb_valid, bus.dmem_req,
               wb_data, e_wb);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    instr_t q[$];
    for (int i = 0; i < 4; i++) q.push_back(mk(0, 4'(i + 8), 16'($urandom), 16'h0));
    @(negedge clk);
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        n_checks++;
        if (wb_valid !== 1'b1 || reg_rd_out !== q[i-1].dst || wb_data !== q[i-1].alu)
          $display("FAIL b2b%0d: got v=%b rd=%h d=%h expected 1 %h %h", i, wb_valid, reg_rd_out,
                   wb_data, q[i-1].dst, q[i-1].alu);
        else n_pass++;
      end
      if (i < 4) drive(q[i], 1'b1);
      else ex_valid = 1'b0;
      #1;
      n_checks++;
      if (mem_stall !== 1'b0) $display("FAIL b2b_stall%0d: got %b expected 0", i, mem_stall);
      else n_pass++;
      @(negedge clk);
    end
    e_regwrite = 1'b1; e_rd = q[3].dst; e_wb = q[3].alu;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      do_instr("rand", mk($urandom_range(0, 4), 4'($urandom), 16'($urandom), 16'($urandom)),
               $urandom_range(1, TO + 1), 16'($urandom));
    end
  endtask

  task automatic test_reset_halt();
    @(negedge clk);
    drive(mk(1, 4'd1, 16'h0100, 16'h0), 1'b1);
    @(negedge clk);
    ex_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.dmem_req !== 1'b0 || wb_valid !== 1'b0 || RegWrite_out !== 1'b0 || wb_data !== '0 ||
        mem_error !== 1'b0 || mem_stall !== 1'b0 || reg_rd_out !== '0)
      $display("FAIL async_reset: got req=%b wbv=%b rw=%b d=%h err=%b stall=%b rd=%h expected all 0",
               bus.dmem_req, wb_valid, RegWrite_out, wb_data, mem_error, mem_stall, reg_rd_out);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    do_instr("halt", mk(5, 4'd0, 16'h0000, 16'h0), 0, 16'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(mk(i, 4'd6, 16'h0777, 16'h0), 1'b1);
      #1;
      n_checks++;
      if (mem_stall !== 1'b0) $display("FAIL halted_stall%0d: got %b expected 0", i, mem_stall);
      else n_pass++;
      @(negedge clk);
      ex_valid = 1'b0;
      n_checks++;
      if (wb_valid !== 1'b0 || bus.dmem_req !== 1'b0 || HALT_out !== 1'b1)
        $display("FAIL halted_ignore%0d: got wbv=%b req=%b halt=%b expected 0 0 1", i, wb_valid,
                 bus.dmem_req, HALT_out);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_ack_outside_wait();
    test_back_to_back();
    test_random();
    test_reset_halt();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage of the 5-stage 16-bit pipeline. It consumes the EX-stage outputs: control bits, ALU result used as address or write-back value, store data, destination register, call/ret/HALT.
- Drives a data memory through a req/ack handshake with variable latency, stalling upstream until the access completes.
- Presents registered MEM/WB results to the write-back stage, including the popped return PC for ret.

Parameters:
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before the access is abandoned (range 1..255).
- DATA_W, 16, datapath width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  EX outputs valid this cycle
- RegWrite_in  in  1  instruction writes the register file
- MemWrite_in  in  1  store; call push
- MemRead_in  in  1  load; ret pop
- mem_to_reg_in  in  1  write-back data comes from memory
- call_in  in  1  call (store PC to stack)
- ret_future_in  in  1  ret (load PC from stack)
- reg_rd_in  in  4  destination register
- alu_result_in  in  16  memory address / ALU write-back value
- sw_data_in  in  16  store data
- HALT_in  in  1  halt instruction
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1 = write
- dmem_addr  out  16  address
- dmem_wdata  out  16  write data
- dmem_rdata  in  16  read data, valid with dmem_ack
- dmem_ack  in  1  one-cycle completion pulse
- mem_stall  out  1  hold EX/MEM inputs stable (combinational)
- wb_valid  out  1  WB outputs valid (one-cycle pulse per instruction)
- RegWrite_out  out  1  register write enable to WB
- reg_rd_out  out  4  destination register to WB
- wb_data  out  16  write-back data
- ret_pc_valid  out  1  pulse: ret_pc valid
- ret_pc  out  16  return address popped from stack
- HALT_out  out  1  sticky halt
- mem_error  out  1  sticky timeout flag

Behaviour:
- Reset (asynchronous):
  - Every output is 0, state = IDLE, timeout counter = 0.
  - A request in flight is dropped immediately.
- FSM states are IDLE and WAIT.
- IDLE, ex_valid = 0: no action; wb_valid = 0 next cycle.
- IDLE, ex_valid = 1, no memory operation: outputs are registered at the next edge.
  - wb_valid = 1, RegWrite_out = RegWrite_in, reg_rd_out = reg_rd_in, wb_data = alu_result_in.
  - Latency is 1 cycle, throughput is 1 instruction per cycle.
- IDLE, ex_valid = 1, MemRead_in or MemWrite_in set:
  - mem_stall = 1 in the same cycle.
  - At the next edge: go to WAIT, capture all inputs, drive the memory bus.
    - dmem_req = 1, dmem_addr = alu_result_in, dmem_we = MemWrite_in, dmem_wdata = sw_data_in.
  - If MemRead_in and MemWrite_in are both set, the write wins.
- WAIT:
  - dmem_req, dmem_addr, dmem_we and dmem_wdata are held constant; the counter increments every cycle.
  - mem_stall = 1 except in the dmem_ack cycle.
- WAIT, dmem_ack = 1: mem_stall = 0. At the next edge:
  - dmem_req = 0, state = IDLE, wb_valid = 1.
  - wb_data = dmem_rdata if mem_to_reg, else the captured alu_result.
  - If ret_future: ret_pc = dmem_rdata, ret_pc_valid = 1, wb_data = captured alu_result (stack-pointer update).
  - call: the store completes normally; wb_data = captured alu_result.
  - The minimum memory access is 2 cycles of occupancy (the earliest ack is the first WAIT cycle).
- dmem_ack outside WAIT is ignored.
- Timeout: when the counter reaches TIMEOUT_CYCLES without an ack, at the next edge:
  - dmem_req = 0, state = IDLE, mem_error = 1 (sticky until reset).
  - wb_valid = 1 with RegWrite_out = 0 and ret_pc_valid = 0.
  - mem_stall is 0 in the timeout cycle.
- HALT:
  - HALT_in is accepted like a non-memory instruction; HALT_out is set with its wb_valid and stays set until reset.
  - After HALT_out, ex_valid is ignored and mem_stall = 0.
- wb_valid and ret_pc_valid are one-cycle pulses. Other WB outputs hold their last value.

Decomposition:
- Shared package wisc_mem_pkg: mem_state_t enum {IDLE, WAIT}, DATA_W, REG_SP = 4'hF.
- No sub-module. The timeout counter and the FSM stay inline.

Test Plan:
- ADD: ex_valid, RegWrite = 1, reg_rd = 3, alu_result = 0x1234 → next cycle wb_valid = 1, reg_rd_out = 3, wb_data = 0x1234, mem_stall never 1.
- LW with ack after 3 WAIT cycles: MemRead, mem_to_reg, addr 0x0040, rdata 0xBEEF → dmem_addr = 0x0040, dmem_we = 0, mem_stall high through the 2nd WAIT cycle and low in the ack cycle, wb_data = 0xBEEF.
- call: MemWrite, call_in, alu_result = 0xFFFE, sw_data = 0x0102, rd = 15, ack on the first WAIT cycle → dmem_we = 1, dmem_wdata = 0x0102, wb_data = 0xFFFE.
- ret: MemRead, ret_future, alu_result = 0xFFFF, rdata = 0x0103 → ret_pc_valid pulse with ret_pc = 0x0103, wb_data = 0xFFFF.
- Timeout with TIMEOUT_CYCLES = 4 and no ack → req drops after 4 WAIT cycles, mem_error = 1, wb_valid with RegWrite_out = 0; a later ADD still completes.
- Reset mid-WAIT, then HALT followed by ADD → dmem_req drops asynchronously and all outputs are 0; afterwards HALT_out = 1 and the ADD produces no wb_valid.
